// File: rtl/music_sequencer.sv
// Beat sequencer for the MusicBox tune ROM: steps the beat address at a programmable
// tempo, reads back the registered note pair, and loops or stops at end of tune.
module music_sequencer #(
    parameter int         CLK_PER_MS = 100000,
    parameter int         LAST_ADDR  = 511,
    parameter logic [6:0] END_CODE   = 7'h7F
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       play,
    input  logic       restart,
    input  logic       loop_en,
    input  logic [9:0] tempo_ms,
    input  logic [6:0] note1_in,
    input  logic [6:0] note2_in,
    output logic [9:0] addr_out,
    output logic       beat_tick,
    output logic       note_valid,
    output logic       playing,
    output logic       song_end
);

    localparam int            PW      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [9:0]    LAST    = 10'(LAST_ADDR);

    typedef enum logic [2:0] {STOP, RUN, FETCH, CHECK, DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    addr_q, addr_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [9:0]    ms_q, ms_d;
    logic          wrap_q, wrap_d;
    logic          beat_q, beat_d;
    logic          nv_q, nv_d;
    logic          play_q, play_d;
    logic          end_q, end_d;
    logic [9:0]    tlast;
    logic          is_end;

    // tempo 0 behaves as 1 ms
    assign tlast  = (tempo_ms == 10'd0) ? 10'd0 : tempo_ms - 10'd1;
    assign is_end = ((note1_in == END_CODE) && (note2_in == END_CODE)) || wrap_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        psc_d   = psc_q;
        ms_d    = ms_q;
        wrap_d  = wrap_q;
        beat_d  = 1'b0;
        end_d   = 1'b0;
        if (restart) begin
            addr_d  = 10'd0;
            psc_d   = '0;
            ms_d    = 10'd0;
            wrap_d  = 1'b0;
            beat_d  = 1'b1;
            state_d = FETCH;
        end else begin
            case (state_q)
                STOP: if (play) state_d = RUN;
                RUN: begin
                    if (!play) begin
                        state_d = STOP;
                    end else if (psc_q == PSC_MAX) begin
                        psc_d = '0;
                        // >= so a shortened tempo ends the beat at the next ms wrap
                        if (ms_q >= tlast) begin
                            ms_d    = 10'd0;
                            beat_d  = 1'b1;
                            state_d = FETCH;
                            if (addr_q == LAST) begin
                                addr_d = 10'd0;
                                wrap_d = 1'b1;
                            end else begin
                                addr_d = addr_q + 10'd1;
                            end
                        end else begin
                            ms_d = ms_q + 10'd1;
                        end
                    end else begin
                        psc_d = psc_q + 1'b1;
                    end
                end
                FETCH: state_d = CHECK;
                CHECK: begin
                    wrap_d = 1'b0;
                    if (is_end) begin
                        end_d = 1'b1;
                        // a marker at address 0 is an empty tune; a wrap-induced end may loop
                        if (loop_en && (addr_q != 10'd0 || wrap_q)) begin
                            addr_d  = 10'd0;
                            beat_d  = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = play ? RUN : STOP;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = STOP;
            endcase
        end
        nv_d   = (state_d == CHECK);
        play_d = (state_d == RUN) || (state_d == FETCH) || (state_d == CHECK);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= STOP;
            addr_q  <= 10'd0;
            psc_q   <= '0;
            ms_q    <= 10'd0;
            wrap_q  <= 1'b0;
            beat_q  <= 1'b0;
            nv_q    <= 1'b0;
            play_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            psc_q   <= psc_d;
            ms_q    <= ms_d;
            wrap_q  <= wrap_d;
            beat_q  <= beat_d;
            nv_q    <= nv_d;
            play_q  <= play_d;
            end_q   <= end_d;
        end
    end

    assign addr_out   = addr_q;
    assign beat_tick  = beat_q;
    assign note_valid = nv_q;
    assign playing    = play_q;
    assign song_end   = end_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed, table-driven bench for music_sequencer with a registered tune ROM model.
module tb_music_sequencer;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       play, restart, loop_en;
    logic [9:0] tempo_ms;
    logic [6:0] note1_in, note2_in;
    logic [9:0] addr_out;
    logic       beat_tick, note_valid, playing, song_end;

    int end_addr;
    int n_pass = 0;
    int n_chk  = 0;

    music_sequencer #(.CLK_PER_MS(4), .LAST_ADDR(7), .END_CODE(7'h7F)) dut (
        .sys_clk(sys_clk), .rst(rst), .play(play), .restart(restart), .loop_en(loop_en),
        .tempo_ms(tempo_ms), .note1_in(note1_in), .note2_in(note2_in), .addr_out(addr_out),
        .beat_tick(beat_tick), .note_valid(note_valid), .playing(playing), .song_end(song_end)
    );

    always #5 sys_clk = ~sys_clk;

    // ROM: one-cycle registered read; end marker only at end_addr, other data never 7F
    always @(posedge sys_clk) begin
        if (int'(addr_out) == end_addr) begin
            note1_in <= 7'h7F;
            note2_in <= 7'h7F;
        end else begin
            note1_in <= {1'b0, addr_out[5:0]};
            note2_in <= {1'b0, ~addr_out[5:0]};
        end
    end

    typedef struct {
        int         ncyc;
        logic       p, r, l;
        logic [9:0] t;
        int         ea;
        logic [9:0] a;
        logic       bt, nv, pl, se;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int n, logic p, logic r, logic l, logic [9:0] t, int ea,
                                logic [9:0] a, logic bt, logic nv, logic pl, logic se);
        vec_t v;
        v.ncyc = n; v.p = p; v.r = r; v.l = l; v.t = t; v.ea = ea;
        v.a = a; v.bt = bt; v.nv = nv; v.pl = pl; v.se = se;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [9:0] a, input logic bt, input logic nv,
                       input logic pl, input logic se);
        logic [13:0] got, exp;
        got = {addr_out, beat_tick, note_valid, playing, song_end};
        exp = {a, bt, nv, pl, se};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got addr=%0d bt=%b nv=%b pl=%b se=%b, want addr=%0d bt=%b nv=%b pl=%b se=%b",
                      name, addr_out, beat_tick, note_valid, playing, song_end, a, bt, nv, pl, se);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        // tempo 3 x 4 clk/ms = 12 RUN cycles per beat
        add(1, 1,0,0,3,-1, 0,0,0,1,0);
        add(11,1,0,0,3,-1, 0,0,0,1,0);
        add(1, 1,0,0,3,-1, 1,1,0,1,0);
        add(1, 1,0,0,3,-1, 1,0,1,1,0);
        add(1, 1,0,0,3,-1, 1,0,0,1,0);
        add(11,1,0,0,3,-1, 1,0,0,1,0);
        add(1, 1,0,0,3,-1, 2,1,0,1,0);
        // pause after 5 RUN cycles of the beat, resume needs 7 more
        add(7, 1,0,0,3,-1, 2,0,0,1,0);
        add(1, 0,0,0,3,-1, 2,0,0,0,0);
        add(19,0,0,0,3,-1, 2,0,0,0,0);
        add(1, 1,0,0,3,-1, 2,0,0,1,0);
        add(6, 1,0,0,3,-1, 2,0,0,1,0);
        add(1, 1,0,0,3,-1, 3,1,0,1,0);
        add(1, 1,0,0,3,-1, 3,0,1,1,0);
        // end marker at 5, no loop
        add(13,1,0,0,3, 5, 4,1,0,1,0);
        add(1, 1,0,0,3, 5, 4,0,1,1,0);
        add(13,1,0,0,3, 5, 5,1,0,1,0);
        add(1, 1,0,0,3, 5, 5,0,1,1,0);
        add(1, 1,0,0,3, 5, 5,0,0,0,1);
        add(3, 0,0,0,3, 5, 5,0,0,0,0);
        add(5, 1,0,0,3, 5, 5,0,0,0,0);
        // loop at marker 5
        add(1, 1,1,1,3, 5, 0,1,0,1,0);
        add(1, 1,0,1,3, 5, 0,0,1,1,0);
        add(13,1,0,1,3, 5, 1,1,0,1,0);
        for (int a = 2; a <= 5; a++) add(14, 1,0,1,3, 5, 10'(a),1,0,1,0);
        add(1, 1,0,1,3, 5, 5,0,1,1,0);
        add(1, 1,0,1,3, 5, 0,1,0,1,1);
        add(1, 1,0,1,3, 5, 0,0,1,1,0);
        add(13,1,0,1,3, 5, 1,1,0,1,0);
        // empty tune never loops
        add(1, 1,1,1,3, 0, 0,1,0,1,0);
        add(1, 1,0,1,3, 0, 0,0,1,1,0);
        add(1, 1,0,1,3, 0, 0,0,0,0,1);
        add(4, 1,0,1,3, 0, 0,0,0,0,0);
        // tempo 0 acts as 1 ms; address 7 -> 0 wrap ends the tune
        add(1, 1,1,0,0,-1, 0,1,0,1,0);
        add(1, 1,0,0,0,-1, 0,0,1,1,0);
        add(5, 1,0,0,0,-1, 1,1,0,1,0);
        for (int a = 2; a <= 7; a++) add(6, 1,0,0,0,-1, 10'(a),1,0,1,0);
        add(6, 1,0,0,0,-1, 0,1,0,1,0);
        add(1, 1,0,0,0,-1, 0,0,1,1,0);
        add(1, 1,0,0,0,-1, 0,0,0,0,1);

        rst = 1'b1; play = 1'b0; restart = 1'b0; loop_en = 1'b0; tempo_ms = 10'd3; end_addr = -1;
        #7;
        chk("reset", 0,0,0,0,0);
        #5 rst = 1'b0;

        foreach (vecs[i]) begin
            play = vecs[i].p; restart = vecs[i].r; loop_en = vecs[i].l;
            tempo_ms = vecs[i].t; end_addr = vecs[i].ea;
            step(vecs[i].ncyc);
            chk($sformatf("vec%0d", i), vecs[i].a, vecs[i].bt, vecs[i].nv, vecs[i].pl, vecs[i].se);
        end

        // restart on the same edge as a tempo expiry at address 3
        play = 1'b1; loop_en = 1'b0; tempo_ms = 10'd0; end_addr = -1;
        restart = 1'b1; step(1); restart = 1'b0;
        step(1); step(5); step(6); step(6);
        chk("reach_a3", 3,1,0,1,0);
        step(2); step(3);
        chk("a3_pre_expiry", 3,0,0,1,0);
        restart = 1'b1; step(1); restart = 1'b0;
        chk("restart_vs_expiry", 0,1,0,1,0);
        step(1);
        chk("restart_check", 0,0,1,1,0);
        step(4);
        chk("restart_run", 0,0,0,1,0);
        step(1);
        chk("restart_next_beat", 1,1,0,1,0);

        // async reset in FETCH
        restart = 1'b1; step(1); restart = 1'b0;
        chk("pre_reset_fetch", 0,1,0,1,0);
        #2 rst = 1'b1;
        #1 chk("async_reset", 0,0,0,0,0);
        play = 1'b0;
        #3 rst = 1'b0;
        step(2);
        chk("post_reset_stop", 0,0,0,0,0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
